// File: rtl/uart_rx_deframer_if.sv
// ---------------------------------------------------------------------------
// uart_rx_deframer_if
// Purpose : groups the frame-capture inputs and the host-side Valid/Ready
//           drain signals of uart_rx_deframer into one bundle.
// Signals :
//   RecievedFlag  SIPO frame-complete level flag          (master -> slave)
//   DataParl[10:0] SIPO frame {stop, parity, data, start}  (master -> slave)
//   Ready         host accepts head entry                  (master -> slave)
//   ClearErr      one-cycle pulse clearing Overrun/ErrCount (master -> slave)
//   DataOut[7:0]  FIFO head data byte                      (slave -> master)
//   Valid         FIFO non-empty                           (slave -> master)
//   ParityErr     FIFO head parity error flag              (slave -> master)
//   FrameErr      FIFO head start/stop error flag          (slave -> master)
//   Overrun       sticky dropped-frame flag                (slave -> master)
//   ErrCount[7:0] saturating count of erroneous frames     (slave -> master)
// ---------------------------------------------------------------------------
interface uart_rx_deframer_if;
    logic        RecievedFlag;
    logic [10:0] DataParl;
    logic        Ready;
    logic        ClearErr;
    logic [7:0]  DataOut;
    logic        Valid;
    logic        ParityErr;
    logic        FrameErr;
    logic        Overrun;
    logic [7:0]  ErrCount;

    // Host / SIPO side: drives frames, handshake and clear.
    modport master (
        output RecievedFlag, DataParl, Ready, ClearErr,
        input  DataOut, Valid, ParityErr, FrameErr, Overrun, ErrCount
    );

    // Deframer side.
    modport slave (
        input  RecievedFlag, DataParl, Ready, ClearErr,
        output DataOut, Valid, ParityErr, FrameErr, Overrun, ErrCount
    );
endinterface

// File: rtl/uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// uart_rx_deframer
// Purpose : captures each completed 11-bit UART frame on the rising edge of
//           RecievedFlag, checks start/parity/stop, and queues
//           {data, ParityErr, FrameErr} in a small FIFO drained through a
//           Valid/Ready handshake. Also keeps a sticky Overrun flag and a
//           saturating error counter.
// Parameters:
//   PARITY_ODD  0 = even parity expected, 1 = odd parity expected
//   FIFO_DEPTH  number of FIFO entries, power of two, >= 2
// Ports   :
//   BaudOut  clock (oversampled baud clock shared with the SIPO)
//   Reset    synchronous active-high reset
//   bus      uart_rx_deframer_if.slave (frame input, drain handshake, status)
// All outputs are driven straight from registers.
// ---------------------------------------------------------------------------
module uart_rx_deframer #(
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                BaudOut,
    input  logic                Reset,
    uart_rx_deframer_if.slave   bus
);

    localparam int             AW        = $clog2(FIFO_DEPTH);
    localparam int             EW        = 10;                 // {data[7:0], perr, ferr}
    localparam logic           LP_ODD    = 1'(PARITY_ODD);
    localparam logic [AW-1:0]  PTR_ONE   = AW'(1);
    localparam logic [AW:0]    CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]    CNT_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]     ERR_MAX   = 8'hFF;

    // ---------------- registers ----------------
    logic              r_flag_q;
    logic [EW-1:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_valid;
    logic [7:0]        r_data_out;
    logic              r_parity_err;
    logic              r_frame_err;
    logic              r_overrun;
    logic [7:0]        r_err_count;

    // ---------------- combinational wires ----------------
    logic              w_new_frame;
    logic              w_parity_err;
    logic              w_frame_err;
    logic [EW-1:0]     w_entry;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_err_frame;
    logic [AW-1:0]     w_wr_ptr_nxt;
    logic [AW-1:0]     w_rd_ptr_nxt;
    logic [AW:0]       w_count_nxt;
    logic [EW-1:0]     w_head_nxt;

    // Frame detection, checks, FIFO push/pop decisions and next-head selection.
    always_comb begin
        w_new_frame  = bus.RecievedFlag & ~r_flag_q;
        w_parity_err = (^bus.DataParl[9:1]) != LP_ODD;
        w_frame_err  = bus.DataParl[0] | ~bus.DataParl[10];
        w_entry      = {bus.DataParl[8:1], w_parity_err, w_frame_err};
        w_err_frame  = w_new_frame & (w_parity_err | w_frame_err);

        w_full       = (r_count == CNT_FULL);
        // r_valid mirrors "count != 0", so an empty FIFO can never pop.
        w_pop        = r_valid & bus.Ready;
        // A full FIFO still accepts a frame when the head leaves in the same cycle.
        w_push       = w_new_frame & (~w_full | w_pop);
        w_drop       = w_new_frame & w_full & ~w_pop;

        if (w_push) begin
            w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
        end else begin
            w_wr_ptr_nxt = r_wr_ptr;
        end

        if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
        end else begin
            w_rd_ptr_nxt = r_rd_ptr;
        end

        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase

        // The entry being written becomes the new head only when it lands on
        // the next read slot (FIFO was empty, or held one entry that pops now).
        if (w_count_nxt == '0) begin
            w_head_nxt = {EW{1'b0}};
        end else if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_nxt = w_entry;
        end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
        end
    end

    // FIFO storage: written only on an accepted push; contents need no reset
    // because the pointers and count define what is valid.
    always_ff @(posedge BaudOut) begin
        if (!Reset && w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // Control state, registered head outputs and error bookkeeping.
    always_ff @(posedge BaudOut) begin
        if (Reset) begin
            // Flag history starts high so a flag already asserted at reset
            // release is not mistaken for a new frame.
            r_flag_q     <= 1'b1;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_valid      <= 1'b0;
            r_data_out   <= 8'h00;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_err_count  <= 8'h00;
        end else begin
            r_flag_q     <= bus.RecievedFlag;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_count      <= w_count_nxt;
            r_valid      <= (w_count_nxt != '0);
            r_data_out   <= w_head_nxt[EW-1:2];
            r_parity_err <= w_head_nxt[1];
            r_frame_err  <= w_head_nxt[0];

            // ClearErr wins over a same-cycle overrun or increment.
            if (bus.ClearErr) begin
                r_overrun <= 1'b0;
            end else if (w_drop) begin
                r_overrun <= 1'b1;
            end else begin
                r_overrun <= r_overrun;
            end

            if (bus.ClearErr) begin
                r_err_count <= 8'h00;
            end else if (w_err_frame && (r_err_count != ERR_MAX)) begin
                r_err_count <= r_err_count + 8'd1;
            end else begin
                r_err_count <= r_err_count;
            end
        end
    end

    assign bus.DataOut   = r_data_out;
    assign bus.Valid     = r_valid;
    assign bus.ParityErr = r_parity_err;
    assign bus.FrameErr  = r_frame_err;
    assign bus.Overrun   = r_overrun;
    assign bus.ErrCount  = r_err_count;

endmodule
